// File: rtl/full_subtractor_pkg.sv
// Shared arithmetic definitions for the ripple-borrow subtractor.
package full_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;

  typedef struct packed {
    logic borrow;
    logic zero;
    logic ovf;
  } sub_flags_t;

  // ZERO is set in reset so the flags stay consistent with a cleared DIFF.
  localparam sub_flags_t FLAGS_RESET = '{borrow: 1'b0, zero: 1'b1, ovf: 1'b0};

  // Signed overflow is the borrow into the MSB differing from the borrow out of it.
  function automatic sub_flags_t make_flags(input logic borrow_out,
                                            input logic borrow_msb_in,
                                            input logic diff_zero);
    sub_flags_t f;
    f.borrow = borrow_out;
    f.zero   = diff_zero;
    f.ovf    = borrow_out ^ borrow_msb_in;
    return f;
  endfunction

endpackage

// File: rtl/full_subtractor_if.sv
// Operand/result bundle for the subtractor; master drives operands, slave returns results.
interface full_subtractor_if #(
  parameter int unsigned WIDTH = full_subtractor_pkg::DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C;
  logic             out_valid;
  logic [WIDTH-1:0] DIFF;
  logic             BORROW;
  logic             ZERO;
  logic             OVF;

  modport master (
    output in_valid, A, B, C,
    input  out_valid, DIFF, BORROW, ZERO, OVF
  );

  modport slave (
    input  in_valid, A, B, C,
    output out_valid, DIFF, BORROW, ZERO, OVF
  );

endinterface

// File: rtl/full_subtractor_cell.sv
// One-bit combinational full-subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & (b | bin)) | (b & bin);

endmodule

// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor computing A - B - C with borrow, zero and overflow flags.
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  full_subtractor_if.slave bus
);

  logic [WIDTH:0]   borrow_chain;
  logic [WIDTH-1:0] diff_c;
  sub_flags_t       flags_c;

  logic             valid_q;
  logic [WIDTH-1:0] diff_q;
  sub_flags_t       flags_q;

  assign borrow_chain[0] = bus.C;

  // Ripple chain: bit i consumes the borrow produced by bit i-1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a    (bus.A[i]),
      .b    (bus.B[i]),
      .bin  (borrow_chain[i]),
      .d    (diff_c[i]),
      .bout (borrow_chain[i+1])
    );
  end

  always_comb begin
    flags_c = FLAGS_RESET;
    flags_c = make_flags(borrow_chain[WIDTH], borrow_chain[WIDTH-1], ~|diff_c);
  end

  // Result registers only load on valid operands; out_valid tracks in_valid each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      diff_q  <= '0;
      flags_q <= FLAGS_RESET;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        diff_q  <= diff_c;
        flags_q <= flags_c;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.DIFF      = diff_q;
  assign bus.BORROW    = flags_q.borrow;
  assign bus.ZERO      = flags_q.zero;
  assign bus.OVF       = flags_q.ovf;

endmodule

// File: tb/tb_full_subtractor.sv
// Scoreboard bench for full_subtractor at WIDTH = 1 and WIDTH = 8 sharing one clock.
module tb_full_subtractor;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       br;
    logic       z;
    logic       o;
  } exp_t;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  exp_t q1[$];
  exp_t q8[$];
  exp_t last1;
  exp_t last8;

  full_subtractor_if #(.WIDTH(1)) if1 ();
  full_subtractor_if #(.WIDTH(8)) if8 ();

  full_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  full_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] d, input logic br, input logic z, input logic o);
    exp_t e;
    e.v  = 1'b1;
    e.d  = d;
    e.br = br;
    e.z  = z;
    e.o  = o;
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e = mk(8'h00, 1'b0, 1'b1, 1'b0);
    e.v = 1'b0;
    return e;
  endfunction

  // Independent 8-bit reference using integer arithmetic.
  function automatic exp_t model8(input int a, input int b, input int c);
    exp_t e;
    int full;
    int sa;
    int sb;
    int sr;
    full = a - b - c;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    sr = sa - sb - c;
    e.v  = 1'b1;
    e.d  = 8'(full);
    e.br = (full < 0);
    e.z  = (e.d == 8'h00);
    e.o  = (sr > 127) || (sr < -128);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set1(input logic v, input logic a, input logic b, input logic c, input exp_t e);
    exp_t p;
    if1.in_valid = v;
    if1.A = a;
    if1.B = b;
    if1.C = c;
    if (v) last1 = e;
    p = last1;
    p.v = v;
    q1.push_back(p);
  endtask

  task automatic set8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input exp_t e);
    exp_t p;
    if8.in_valid = v;
    if8.A = a;
    if8.B = b;
    if8.C = c;
    if (v) last8 = e;
    p = last8;
    p.v = v;
    q8.push_back(p);
  endtask

  // Advance one edge and compare both DUTs against the head of their scoreboards.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (q1.size() == 0) begin
      chk("w1 scoreboard empty", 8'd0, 8'd1);
    end else begin
      e = q1.pop_front();
      chk("w1 out_valid", 8'(if1.out_valid), 8'(e.v));
      chk("w1 DIFF",      8'(if1.DIFF),      8'(e.d[0]));
      chk("w1 BORROW",    8'(if1.BORROW),    8'(e.br));
      chk("w1 ZERO",      8'(if1.ZERO),      8'(e.z));
      chk("w1 OVF",       8'(if1.OVF),       8'(e.o));
    end
    if (q8.size() == 0) begin
      chk("w8 scoreboard empty", 8'd0, 8'd1);
    end else begin
      e = q8.pop_front();
      chk("w8 out_valid", 8'(if8.out_valid), 8'(e.v));
      chk("w8 DIFF",      if8.DIFF,          e.d);
      chk("w8 BORROW",    8'(if8.BORROW),    8'(e.br));
      chk("w8 ZERO",      8'(if8.ZERO),      8'(e.z));
      chk("w8 OVF",       8'(if8.OVF),       8'(e.o));
    end
  endtask

  task automatic chk_reset_now(input string tag);
    chk({tag, " w1 out_valid"}, 8'(if1.out_valid), 8'd0);
    chk({tag, " w1 DIFF"},      8'(if1.DIFF),      8'd0);
    chk({tag, " w1 BORROW"},    8'(if1.BORROW),    8'd0);
    chk({tag, " w1 ZERO"},      8'(if1.ZERO),      8'd1);
    chk({tag, " w1 OVF"},       8'(if1.OVF),       8'd0);
    chk({tag, " w8 out_valid"}, 8'(if8.out_valid), 8'd0);
    chk({tag, " w8 DIFF"},      if8.DIFF,          8'd0);
    chk({tag, " w8 BORROW"},    8'(if8.BORROW),    8'd0);
    chk({tag, " w8 ZERO"},      8'(if8.ZERO),      8'd1);
    chk({tag, " w8 OVF"},       8'(if8.OVF),       8'd0);
  endtask

  initial begin
    logic [7:0] d_tab;
    logic [7:0] b_tab;
    logic [7:0] o_tab;
    exp_t       idle;
    int         ra;
    int         rb;
    int         rc;

    n_cmp = 0;
    n_err = 0;
    last1 = reset_exp();
    last8 = reset_exp();
    idle  = reset_exp();
    // Truth table indexed by {A,B,C}.
    d_tab = 8'b1001_0110;
    b_tab = 8'b1000_1110;
    o_tab = 8'b0010_0100;

    rst_n = 1'b0;
    if1.in_valid = 1'b0; if1.A = 1'b0; if1.B = 1'b0; if1.C = 1'b0;
    if8.in_valid = 1'b0; if8.A = 8'h00; if8.B = 8'h00; if8.C = 1'b0;

    #12;
    chk_reset_now("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // WIDTH = 1: all eight operand combinations back to back.
    for (int i = 0; i < 8; i++) begin
      set1(1'b1, i[2], i[1], i[0], mk(8'(d_tab[i]), b_tab[i], ~d_tab[i], o_tab[i]));
      set8(1'b0, 8'h00, 8'h00, 1'b0, idle);
      tick();
    end

    // WIDTH = 8 directed corners, pipelined back to back.
    set1(1'b0, 1'b0, 1'b0, 1'b0, idle);
    set8(1'b1, 8'h05, 8'h03, 1'b0, mk(8'h02, 1'b0, 1'b0, 1'b0));
    tick();
    set1(1'b0, 1'b0, 1'b0, 1'b0, idle);
    set8(1'b1, 8'h00, 8'h01, 1'b0, mk(8'hFF, 1'b1, 1'b0, 1'b0));
    tick();
    set1(1'b0, 1'b0, 1'b0, 1'b0, idle);
    set8(1'b1, 8'h10, 8'h0F, 1'b1, mk(8'h00, 1'b0, 1'b1, 1'b0));
    tick();
    set1(1'b0, 1'b0, 1'b0, 1'b0, idle);
    set8(1'b1, 8'h80, 8'h01, 1'b0, mk(8'h7F, 1'b0, 1'b0, 1'b1));
    tick();
    set1(1'b0, 1'b0, 1'b0, 1'b0, idle);
    set8(1'b1, 8'h7F, 8'hFF, 1'b0, mk(8'h80, 1'b1, 1'b0, 1'b1));
    tick();

    // Idle for three cycles with changing operands: results must hold.
    for (int i = 0; i < 3; i++) begin
      set1(1'b0, 1'b1, 1'b0, 1'(i), idle);
      set8(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, idle);
      tick();
    end

    // Random 8-bit operands against the integer model.
    for (int i = 0; i < 12; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      rc = int'($urandom_range(0, 1));
      set1(1'b1, ra[0], rb[0], rc[0],
           mk(8'(d_tab[{ra[0], rb[0], rc[0]}]), b_tab[{ra[0], rb[0], rc[0]}],
              ~d_tab[{ra[0], rb[0], rc[0]}], o_tab[{ra[0], rb[0], rc[0]}]));
      set8(1'b1, 8'(ra), 8'(rb), rc[0], model8(ra, rb, rc));
      tick();
    end

    // Reset between edges while a result is pending and another is being presented.
    set1(1'b1, 1'b1, 1'b0, 1'b0, mk(8'h01, 1'b0, 1'b0, 1'b0));
    set8(1'b1, 8'h33, 8'h11, 1'b0, mk(8'h22, 1'b0, 1'b0, 1'b0));
    tick();
    set1(1'b1, 1'b0, 1'b1, 1'b0, idle);
    set8(1'b1, 8'h00, 8'h05, 1'b0, idle);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_now("async reset");
    q1.delete();
    q8.delete();
    last1 = reset_exp();
    last8 = reset_exp();
    @(posedge clk);
    #1;
    chk_reset_now("reset held");
    rst_n = 1'b1;

    // First operation after reset release.
    set1(1'b1, 1'b1, 1'b1, 1'b1, mk(8'h01, 1'b1, 1'b0, 1'b0));
    set8(1'b1, 8'hFF, 8'h01, 1'b1, mk(8'hFD, 1'b0, 1'b0, 1'b0));
    tick();
    set1(1'b0, 1'b0, 1'b0, 1'b0, idle);
    set8(1'b0, 8'h00, 8'h00, 1'b0, idle);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
